// File: rtl/mc_control.sv
// Multi-cycle main controller for the MIPS-subset CPU: sequences the shared
// datapath per opcode, stalls on the unified-memory acknowledge, counts retires.
module mc_control (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  Op_i,
  input  logic        mem_ack_i,
  output logic        PCWrite_o,
  output logic        PCWriteCond_o,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        MemtoReg_o,
  output logic        RegDst_o,
  output logic        RegWrite_o,
  output logic        ALUSrcA_o,
  output logic        ExtOp_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic [1:0]  PCSource_o,
  output logic [3:0]  state_o,
  output logic        retire_o,
  output logic [15:0] retire_cnt_o,
  output logic        illegal_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  state_e      state_q;
  state_e      state_d;
  logic [15:0] retire_cnt_q;
  logic        illegal_q;
  logic        retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      retire_cnt_q <= 16'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 16'd1;
      end
      if (state_d == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Final states hand back to FETCH only while the run enable is still high.
  function automatic state_e after_retire(input logic run);
    return run ? S_FETCH : S_IDLE;
  endfunction

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (Op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        // Opcode is re-read here; anything but lw/sw means IR changed under us.
        case (Op_i)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMRD: begin
        if (mem_ack_i) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (mem_ack_i) begin
          retire  = 1'b1;
          state_d = after_retire(start_i);
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        retire  = 1'b1;
        state_d = after_retire(start_i);
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ExtOp_o       = 1'b1;
    ALUSrcB_o     = SRCB_REG;
    ALUOp_o       = ALU_ADD;
    PCSource_o    = PCS_ALU;
    unique case (state_q)
      S_FETCH: begin
        MemRead_o  = 1'b1;
        ALUSrcB_o  = SRCB_FOUR;
        IRWrite_o  = mem_ack_i;
        PCWrite_o  = mem_ack_i;
      end
      S_DECODE: begin
        ALUSrcB_o  = SRCB_IMM4;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead_o  = 1'b1;
        IorD_o     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCS_ALUOUT;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = PCS_JUMP;
      end
      default: begin
        ExtOp_o    = 1'b0;
      end
    endcase
  end

  assign state_o      = state_q;
  assign retire_o     = retire;
  assign retire_cnt_o = retire_cnt_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction latencies, memory stalls, reset
// mid-access, stop request, illegal opcode and retire-counter wrap.
module tb_mc_control;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [5:0]  Op_i;
  logic        mem_ack_i;
  logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic        MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ExtOp_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0]  state_o;
  logic        retire_o;
  logic [15:0] retire_cnt_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  mc_control dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .Op_i          (Op_i),
    .mem_ack_i     (mem_ack_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegDst_o      (RegDst_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ExtOp_o       (ExtOp_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALUOp_o       (ALUOp_o),
    .PCSource_o    (PCSource_o),
    .state_o       (state_o),
    .retire_o      (retire_o),
    .retire_cnt_o  (retire_cnt_o),
    .illegal_o     (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [16:0] ctrl;
  assign ctrl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                 MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ExtOp_o,
                 ALUSrcB_o, ALUOp_o, PCSource_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected control word per state, written from the state table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic ack);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ext;
    logic [1:0] asb, aop, pcs;
    pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0;
    m2r = 0; rd = 0; rw = 0; asa = 0; ext = 1;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd1:  begin mr = 1; asb = 2'b01; irw = ack; pcw = ack; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; iord = 1; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      4'd11: begin asa = 1; asb = 2'b10; end
      4'd12: rw = 1;
      default: ext = 0;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ext, asb, aop, pcs};
  endfunction

  // R-type, addi, lw, sw, beq, j back to back with immediate acks.
  function automatic logic [5:0] op_for(input int c);
    if (c <= 4)  return OP_RTYPE;
    if (c <= 8)  return OP_ADDI;
    if (c <= 13) return OP_LW;
    if (c <= 17) return OP_SW;
    if (c <= 20) return OP_BEQ;
    return OP_J;
  endfunction

  logic [3:0] seq_state [1:23];
  int bad;

  initial begin
    seq_state = '{4'd1, 4'd2, 4'd7, 4'd8,
                  4'd1, 4'd2, 4'd11, 4'd12,
                  4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                  4'd1, 4'd2, 4'd3, 4'd6,
                  4'd1, 4'd2, 4'd9,
                  4'd1, 4'd2, 4'd10};

    rst_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b0; Op_i = OP_RTYPE;
    #12;
    check("rst_state", state_o, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_cnt", retire_cnt_o, 0);
    check("rst_illegal", illegal_o, 0);

    rst_i = 1'b1; start_i = 1'b1; mem_ack_i = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      Op_i = op_for(c);
      #1;
      check($sformatf("seq_state_c%0d", c), state_o, seq_state[c]);
      check($sformatf("seq_ctrl_c%0d", c), ctrl, exp_ctrl(seq_state[c], 1'b1));
      check($sformatf("seq_retire_c%0d", c), retire_o,
            (c == 4 || c == 8 || c == 13 || c == 17 || c == 20 || c == 23) ? 1 : 0);
    end
    tick();
    Op_i = OP_LW;
    #1;
    check("seq_cnt", retire_cnt_o, 6);
    check("seq_refetch", state_o, 1);

    // lw stalled in MEMRD, then asynchronous reset mid-access
    tick();
    mem_ack_i = 1'b0;
    tick();
    tick();
    check("stall_memrd", state_o, 4);
    tick();
    check("stall_memrd_hold", state_o, 4);
    check("stall_memrd_ctrl", ctrl, exp_ctrl(4'd4, 1'b0));
    rst_i = 1'b0;
    #1;
    check("midrst_state", state_o, 0);
    check("midrst_ctrl", ctrl, 0);
    check("midrst_cnt", retire_cnt_o, 0);
    check("midrst_retire", retire_o, 0);

    // Fetch stall for three cycles, ack on the fourth, then stop request in EXEC
    #2;
    rst_i = 1'b1; start_i = 1'b1; mem_ack_i = 1'b0; Op_i = OP_RTYPE;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fstall_state_%0d", k), state_o, 1);
      check($sformatf("fstall_ctrl_%0d", k), ctrl, exp_ctrl(4'd1, 1'b0));
    end
    tick();
    mem_ack_i = 1'b1;
    #1;
    check("fstall_ack_state", state_o, 1);
    check("fstall_ack_irw", IRWrite_o, 1);
    check("fstall_ack_pcw", PCWrite_o, 1);
    tick();
    check("fstall_decode", state_o, 2);
    check("fstall_decode_irw", IRWrite_o, 0);
    tick();
    start_i = 1'b0;
    #1;
    check("stop_exec", state_o, 7);
    tick();
    check("stop_rwb", state_o, 8);
    check("stop_rwb_retire", retire_o, 1);
    tick();
    check("stop_idle", state_o, 0);
    check("stop_cnt", retire_cnt_o, 1);
    tick();
    check("stop_idle_hold", state_o, 0);

    // Illegal opcode: sticky, ignores start_i, never retires
    rst_i = 1'b0;
    #3;
    rst_i = 1'b1; start_i = 1'b1; mem_ack_i = 1'b1; Op_i = 6'b111111;
    tick();
    tick();
    check("ill_decode", state_o, 2);
    check("ill_decode_flag", illegal_o, 0);
    tick();
    check("ill_state", state_o, 13);
    check("ill_flag", illegal_o, 1);
    check("ill_ctrl", ctrl, 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (state_o !== 4'd13 || illegal_o !== 1'b1 || retire_o !== 1'b0) bad++;
    end
    check("ill_hold100", bad, 0);
    check("ill_cnt", retire_cnt_o, 0);

    // Counter wrap: preload stands in for 65534 earlier retires
    rst_i = 1'b0;
    #3;
    rst_i = 1'b1; start_i = 1'b0;
    force dut.retire_cnt_q = 16'hFFFE;
    #1;
    release dut.retire_cnt_q;
    #1;
    check("wrap_preload", retire_cnt_o, 16'hFFFE);
    start_i = 1'b1; mem_ack_i = 1'b1; Op_i = OP_J;
    tick();
    tick();
    tick();
    check("wrap_jump", state_o, 10);
    check("wrap_jump_retire", retire_o, 1);
    tick();
    Op_i = OP_SW;
    #1;
    check("wrap_ffff", retire_cnt_o, 16'hFFFF);
    tick();
    tick();
    mem_ack_i = 1'b0;
    tick();
    check("sw_memwr", state_o, 6);
    check("sw_stall_retire", retire_o, 0);
    check("sw_memwr_ctrl", ctrl, exp_ctrl(4'd6, 1'b0));
    tick();
    mem_ack_i = 1'b1;
    #1;
    check("sw_hold", state_o, 6);
    check("sw_ack_retire", retire_o, 1);
    tick();
    check("wrap_zero", retire_cnt_o, 16'h0000);
    check("sw_refetch", state_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
